// File: rtl/inv_mixcolumn_serial_8.sv
// inv_mixcolumn_serial_8
// Byte-serial AES InvMixColumns: four column bytes a0..a3 in, four result
// bytes b0..b3 out, over GF(2^8) with polynomial 0x11B. A four-byte output
// buffer lets the next column accumulate while the previous one drains.
// Optional macro INV_MIXCOL_FWD_EN adds a 'fwd' input that switches the
// coefficients to forward MixColumns, sampled on a0 and held for the column.
module inv_mixcolumn_serial_8 (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       clr,
`ifdef INV_MIXCOL_FWD_EN
  input  logic       fwd,
`endif
  input  logic       in_valid,
  output logic       in_ready,
  input  logic [7:0] in_data,
  output logic       out_valid,
  input  logic       out_ready,
  output logic [7:0] out_data,
  output logic       out_last,
  output logic       busy
);

  localparam logic [0:0] ST_EMPTY = 1'b0;
  localparam logic [0:0] ST_DRAIN = 1'b1;

  logic [0:0] state;
  logic [1:0] in_cnt;
  logic [1:0] out_cnt;
  logic [7:0] acc      [4];
  logic [7:0] acc_next [4];
  logic [7:0] term     [4];
  logic [7:0] obuf     [4];

  logic [7:0] x1, x2, x4, x8;
  logic [7:0] p2, p3, p9, pb, pd, pe;
  logic       col_fwd;
  logic       in_fire;
  logic       out_fire;
  logic       commit;

  // Multiply by x (0x02) in GF(2^8), reducing by 0x11B.
  function automatic logic [7:0] xtime(input logic [7:0] v);
    return {v[6:0], 1'b0} ^ (v[7] ? 8'h1b : 8'h00);
  endfunction

  // Products of the incoming byte built from a shared xtime chain.
  always_comb begin
    x1 = in_data;
    x2 = xtime(x1);
    x4 = xtime(x2);
    x8 = xtime(x4);
    p2 = x2;
    p3 = x2 ^ x1;
    p9 = x8 ^ x1;
    pb = x8 ^ x2 ^ x1;
    pd = x8 ^ x4 ^ x1;
    pe = x8 ^ x4 ^ x2;
  end

`ifdef INV_MIXCOL_FWD_EN
  logic fwd_q;

  // The a0 byte uses fwd directly; later bytes of the column use the held copy.
  assign col_fwd = (in_cnt == 2'd0) ? fwd : fwd_q;

  // Capture the direction on a0 so mid-column changes are ignored.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fwd_q <= 1'b0;
    end else if (!clr && in_fire && (in_cnt == 2'd0)) begin
      fwd_q <= fwd;
    end
  end
`else
  assign col_fwd = 1'b0;
`endif

  // Per output byte i, pick coefficient c[(j-i) mod 4] for the byte index j = in_cnt.
  always_comb begin
    for (int i = 0; i < 4; i++) begin
      term[i] = 8'h00;
      case (in_cnt - i[1:0])
        2'd0:    term[i] = col_fwd ? p2 : pe;
        2'd1:    term[i] = col_fwd ? p3 : pb;
        2'd2:    term[i] = col_fwd ? x1 : pd;
        default: term[i] = col_fwd ? x1 : p9;
      endcase
      acc_next[i] = acc[i] ^ term[i];
    end
  end

  // The final byte a3 waits only while the buffer still holds undrained bytes.
  assign in_ready  = !((in_cnt == 2'd3) && (state == ST_DRAIN) &&
                       !((out_cnt == 2'd3) && out_ready));
  assign in_fire   = in_valid & in_ready;
  assign commit    = in_fire & (in_cnt == 2'd3);
  assign out_valid = (state == ST_DRAIN);
  assign out_fire  = out_valid & out_ready;
  assign out_last  = out_valid & (out_cnt == 2'd3);
  assign busy      = (in_cnt != 2'd0) | (state == ST_DRAIN);

  // Output byte mux; reads zero whenever nothing is buffered.
  always_comb begin
    out_data = 8'h00;
    if (state == ST_DRAIN) begin
      out_data = obuf[out_cnt];
    end
  end

  // Byte counter and accumulators; a flush or a completed column restarts them.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      in_cnt <= 2'd0;
      for (int i = 0; i < 4; i++) acc[i] <= 8'h00;
    end else if (clr) begin
      in_cnt <= 2'd0;
      for (int i = 0; i < 4; i++) acc[i] <= 8'h00;
    end else if (in_fire) begin
      in_cnt <= in_cnt + 2'd1;
      for (int i = 0; i < 4; i++) acc[i] <= commit ? 8'h00 : acc_next[i];
    end
  end

  // Output buffer loads the finished column including the a3 contribution.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 4; i++) obuf[i] <= 8'h00;
    end else if (!clr && commit) begin
      for (int i = 0; i < 4; i++) obuf[i] <= acc_next[i];
    end
  end

  // Drain FSM: a commit always (re)starts at b0, otherwise step per handshake.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= ST_EMPTY;
      out_cnt <= 2'd0;
    end else if (clr) begin
      state   <= ST_EMPTY;
      out_cnt <= 2'd0;
    end else if (commit) begin
      state   <= ST_DRAIN;
      out_cnt <= 2'd0;
    end else if (out_fire) begin
      if (out_cnt == 2'd3) begin
        state   <= ST_EMPTY;
        out_cnt <= 2'd0;
      end else begin
        out_cnt <= out_cnt + 2'd1;
      end
    end
  end

endmodule

// File: tb/tb_inv_mixcolumn_serial_8.sv
// tb_inv_mixcolumn_serial_8
// Drives directed columns and a randomized-gap stream into
// inv_mixcolumn_serial_8 and compares every cycle against a column-level
// GF(2^8) model with a byte queue for the output buffer.
module tb_inv_mixcolumn_serial_8;

  logic       clk;
  logic       rst_n;
  logic       clr;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] in_data;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] out_data;
  logic       out_last;
  logic       busy;
`ifdef INV_MIXCOL_FWD_EN
  logic       fwd;
`endif

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  bit rand_mode = 0;

  logic [7:0] part[$];
  logic [7:0] exp_q[$];
  logic [7:0] obs_data[$];
  logic       obs_last[$];
  int         obs_cyc[$];
  int         pend;
  int         mc;
  logic       exp_ready;
  logic       col_fwd;
  logic [31:0] col_in;
  logic [31:0] col_out;

  inv_mixcolumn_serial_8 dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .clr       (clr),
`ifdef INV_MIXCOL_FWD_EN
    .fwd       (fwd),
`endif
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_last  (out_last),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Generic GF(2^8) multiply by shift-and-add.
  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p = 8'h00;
    logic [7:0] x = a;
    for (int k = 0; k < 8; k++) begin
      if (b[k]) p = p ^ x;
      x = x[7] ? ((x << 1) ^ 8'h1b) : (x << 1);
    end
    return p;
  endfunction

  // Column matrix product; a0 sits in bits 31:24.
  function automatic logic [31:0] mix_col(input logic [31:0] a, input logic f);
    logic [7:0] c [4];
    logic [7:0] av [4];
    logic [7:0] r;
    logic [31:0] res = 32'h0;
    if (f) begin c[0] = 8'h02; c[1] = 8'h03; c[2] = 8'h01; c[3] = 8'h01; end
    else   begin c[0] = 8'h0e; c[1] = 8'h0b; c[2] = 8'h0d; c[3] = 8'h09; end
    for (int j = 0; j < 4; j++) av[j] = a[31-8*j -: 8];
    for (int i = 0; i < 4; i++) begin
      r = 8'h00;
      for (int j = 0; j < 4; j++) r = r ^ gmul(c[(j - i + 4) % 4], av[j]);
      res[31-8*i -: 8] = r;
    end
    return res;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("[TB] FAIL %s actual=%0h required=%0h t=%0t", name, act, req, $time);
    end
  endtask

  task automatic flag_fail(input string name);
    checks++;
    errors++;
    $display("[TB] FAIL %s actual=timeout required=progress t=%0t", name, $time);
  endtask

  // Per-cycle comparison against the model, then advance the model as the edge will.
  always @(negedge clk) begin
    cyc++;
    if (!rst_n) begin
      part.delete();
      exp_q.delete();
    end else begin
      pend = exp_q.size();
      mc   = part.size();
      exp_ready = !(mc == 3 && pend > 0 && !(pend == 1 && out_ready));
      checkOutput("in_ready", {31'b0, in_ready}, {31'b0, exp_ready});
      checkOutput("out_valid", {31'b0, out_valid}, {31'b0, pend > 0});
      checkOutput("busy", {31'b0, busy}, {31'b0, (mc != 0) || (pend > 0)});
      if (pend > 0) begin
        checkOutput("out_data", {24'b0, out_data}, {24'b0, exp_q[0]});
        checkOutput("out_last", {31'b0, out_last}, {31'b0, pend == 1});
      end else begin
        checkOutput("out_data_idle", {24'b0, out_data}, 32'h0);
        checkOutput("out_last_idle", {31'b0, out_last}, 32'h0);
      end
      if (out_valid && out_ready && !clr) begin
        obs_data.push_back(out_data);
        obs_last.push_back(out_last);
        obs_cyc.push_back(cyc);
      end
      if (clr) begin
        part.delete();
        exp_q.delete();
      end else begin
        if (pend > 0 && out_ready) void'(exp_q.pop_front());
        if (in_valid && exp_ready) begin
`ifdef INV_MIXCOL_FWD_EN
          if (mc == 0) col_fwd = fwd;
`else
          col_fwd = 1'b0;
`endif
          part.push_back(in_data);
          if (part.size() == 4) begin
            col_in  = {part[0], part[1], part[2], part[3]};
            col_out = mix_col(col_in, col_fwd);
            for (int k = 0; k < 4; k++) exp_q.push_back(col_out[31-8*k -: 8]);
            part.delete();
          end
        end
      end
    end
  end

  task automatic cycle();
    @(posedge clk);
    #1;
    if (rand_mode) out_ready = ($urandom_range(0, 3) != 0);
  endtask

  // Offer one byte until accepted; reports how many cycles it stalled.
  task automatic applyStimulus(input logic [7:0] d, output int stalls);
    logic ok;
    bit   done = 0;
    stalls   = 0;
    in_valid = 1'b1;
    in_data  = d;
    for (int t = 0; t < 200; t++) begin
      @(negedge clk);
      ok = in_ready;
      cycle();
      if (ok) begin
        done = 1;
        break;
      end
      stalls++;
    end
    in_valid = 1'b0;
    if (!done) flag_fail("in_accept_timeout");
  endtask

  task automatic send_col(input logic [31:0] col, output int stalls);
    int s;
    stalls = 0;
    for (int k = 0; k < 4; k++) begin
      applyStimulus(col[31-8*k -: 8], s);
      stalls += s;
    end
  endtask

  task automatic wait_drain(input int budget);
    bit done = 0;
    for (int t = 0; t < budget; t++) begin
      if (exp_q.size() == 0) begin
        done = 1;
        break;
      end
      cycle();
    end
    if (!done) flag_fail("drain_timeout");
  endtask

  // Compare four logged output bytes starting at base against a literal column.
  task automatic expect_col(input string name, input int base, input logic [31:0] col);
    for (int k = 0; k < 4; k++) begin
      if (base + k < obs_data.size()) begin
        checkOutput($sformatf("%s_b%0d", name, k), {24'b0, obs_data[base+k]}, {24'b0, col[31-8*k -: 8]});
        checkOutput($sformatf("%s_last%0d", name, k), {31'b0, obs_last[base+k]}, {31'b0, k == 3});
      end else begin
        flag_fail($sformatf("%s_missing_b%0d", name, k));
      end
    end
  endtask

  initial begin
    #5_000_000;
    $display("[TB] FAIL watchdog actual=running required=finished");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int base;
    int st;
    logic [31:0] rc;
    rst_n     = 1'b0;
    clr       = 1'b0;
    in_valid  = 1'b0;
    in_data   = 8'h00;
    out_ready = 1'b0;
`ifdef INV_MIXCOL_FWD_EN
    fwd       = 1'b0;
`endif
    #2;
    checkOutput("rst_in_ready", {31'b0, in_ready}, 32'h1);
    checkOutput("rst_out_valid", {31'b0, out_valid}, 32'h0);
    checkOutput("rst_out_data", {24'b0, out_data}, 32'h0);
    checkOutput("rst_out_last", {31'b0, out_last}, 32'h0);
    checkOutput("rst_busy", {31'b0, busy}, 32'h0);

    checkOutput("model_8e", mix_col(32'h8e4da1bc, 1'b0), 32'hdb135345);
    checkOutput("model_9f", mix_col(32'h9fdc589d, 1'b0), 32'hf20a225c);
    checkOutput("model_c6", mix_col(32'hc6c6c6c6, 1'b0), 32'hc6c6c6c6);
    checkOutput("model_01", mix_col(32'h01010101, 1'b0), 32'h01010101);
    checkOutput("model_fwd", mix_col(32'hdb135345, 1'b1), 32'h8e4da1bc);

    @(posedge clk);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    cycle();

    $display("[TB] single column, b0 one cycle after a3");
    out_ready = 1'b1;
    base = obs_data.size();
    send_col(32'h8e4da1bc, st);
    checkOutput("t1_valid_after_a3", {31'b0, out_valid}, 32'h1);
    checkOutput("t1_b0_after_a3", {24'b0, out_data}, 32'hdb);
    wait_drain(20);
    expect_col("t1", base, 32'hdb135345);

    $display("[TB] back-to-back columns");
    base = obs_data.size();
    send_col(32'h9fdc589d, st);
    begin
      int st2;
      send_col(32'h01010101, st2);
      st += st2;
    end
    checkOutput("t2_stalls", st, 0);
    wait_drain(20);
    expect_col("t2a", base, 32'hf20a225c);
    expect_col("t2b", base + 4, 32'h01010101);
    if (obs_cyc.size() >= base + 8)
      checkOutput("t2_no_bubbles", obs_cyc[base+7] - obs_cyc[base], 7);
    else
      flag_fail("t2_short");

    $display("[TB] backpressure holds a3");
    out_ready = 1'b0;
    base = obs_data.size();
    send_col(32'hc6c6c6c6, st);
    checkOutput("t3_col1_stalls", st, 0);
    st = 0;
    for (int k = 0; k < 3; k++) begin
      int s;
      rc = 32'h8e4da1bc;
      applyStimulus(rc[31-8*k -: 8], s);
      st += s;
    end
    checkOutput("t3_a012_stalls", st, 0);
    in_valid = 1'b1;
    in_data  = 8'hbc;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      checkOutput("t3_a3_held", {31'b0, in_ready}, 32'h0);
      cycle();
    end
    out_ready = 1'b1;
    applyStimulus(8'hbc, st);
    checkOutput("t3_a3_wait", st, 3);
    wait_drain(20);
    expect_col("t3a", base, 32'hc6c6c6c6);
    expect_col("t3b", base + 4, 32'hdb135345);

    $display("[TB] clr mid-column and reset during drain");
    base = obs_data.size();
    applyStimulus(8'h11, st);
    applyStimulus(8'h22, st);
    clr      = 1'b1;
    in_valid = 1'b1;
    in_data  = 8'h33;
    cycle();
    clr      = 1'b0;
    in_valid = 1'b0;
    send_col(32'h8e4da1bc, st);
    wait_drain(20);
    checkOutput("t4_count", obs_data.size() - base, 4);
    expect_col("t4", base, 32'hdb135345);
    out_ready = 1'b0;
    send_col(32'h9fdc589d, st);
    rst_n = 1'b0;
    #1;
    checkOutput("t4_rst_out_valid", {31'b0, out_valid}, 32'h0);
    checkOutput("t4_rst_in_ready", {31'b0, in_ready}, 32'h1);
    checkOutput("t4_rst_busy", {31'b0, busy}, 32'h0);
    checkOutput("t4_rst_out_data", {24'b0, out_data}, 32'h0);
    cycle();
    rst_n     = 1'b1;
    out_ready = 1'b1;
    cycle();

    $display("[TB] random gaps, 1000 columns");
    base = obs_data.size();
    rand_mode = 1;
    for (int c = 0; c < 1000; c++) begin
      for (int k = 0; k < 4; k++) begin
        if ($urandom_range(0, 3) == 0) cycle();
        applyStimulus(8'($urandom_range(0, 255)), st);
      end
    end
    wait_drain(200);
    rand_mode = 0;
    out_ready = 1'b1;
    checkOutput("t5_byte_count", obs_data.size() - base, 4000);

`ifdef INV_MIXCOL_FWD_EN
    $display("[TB] forward direction");
    cycle();
    base = obs_data.size();
    fwd = 1'b1;
    send_col(32'hdb135345, st);
    wait_drain(20);
    expect_col("t6a", base, 32'h8e4da1bc);
    base = obs_data.size();
    fwd = 1'b0;
    applyStimulus(8'h8e, st);
    fwd = 1'b1;
    applyStimulus(8'h4d, st);
    applyStimulus(8'ha1, st);
    applyStimulus(8'hbc, st);
    wait_drain(20);
    expect_col("t6b", base, 32'hdb135345);
    fwd = 1'b0;
`endif

    cycle();
    cycle();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
